// File: rtl/rc_scheduler.sv
// Shares one icapi bitstream engine among NUM_REQ requesters: a descriptor table,
// round-robin grant, start/done handshake with timeout, and per-requester ack/err.
module rc_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MID_W   = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [NUM_REQ*MID_W-1:0] req_mid,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy,
  output logic                     fault,
  input  logic                     tbl_we,
  input  logic [MID_W-1:0]         tbl_waddr,
  input  logic [31:0]              tbl_baddr,
  input  logic [31:0]              tbl_bsize,
  output logic                     rc_start,
  output logic                     rc_bop,
  output logic [31:0]              rc_baddr,
  output logic [31:0]              rc_bsize,
  input  logic                     rc_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 2 ** MID_W;
  localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_START, S_WAIT, S_ACK, S_FAULT
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     rr_q;
  logic [IDX_W-1:0]     gnt_q;
  logic                 op_q;
  logic [MID_W-1:0]     mid_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 fault_q;
  logic                 rc_start_q;
  logic                 rc_bop_q;
  logic [31:0]          rc_baddr_q;
  logic [31:0]          rc_bsize_q;

  logic [31:0]          tbl_baddr_q [DEPTH];
  logic [31:0]          tbl_bsize_q [DEPTH];

  logic [IDX_W-1:0]     gnt_d;
  logic                 found_d;
  int                   arb_idx;

  // Descriptor table: writable in every state; LOOKUP reads the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_baddr_q[i] <= '0;
        tbl_bsize_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_baddr_q[tbl_waddr] <= tbl_baddr;
      tbl_bsize_q[tbl_waddr] <= tbl_bsize;
    end
  end

  // Round-robin search: first set req bit at or above rr_q, wrapping.
  always_comb begin
    gnt_d   = '0;
    found_d = 1'b0;
    arb_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_q) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!found_d && req[arb_idx]) begin
        found_d = 1'b1;
        gnt_d   = IDX_W'(arb_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      op_q       <= 1'b0;
      mid_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      rc_start_q <= 1'b0;
      rc_bop_q   <= 1'b0;
      rc_baddr_q <= '0;
      rc_bsize_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gnt_q   <= gnt_d;
            op_q    <= req_op[gnt_d];
            mid_q   <= req_mid[gnt_d*MID_W +: MID_W];
            busy_q  <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          rc_baddr_q <= tbl_baddr_q[mid_q];
          rc_bsize_q <= tbl_bsize_q[mid_q];
          rc_bop_q   <= op_q;
          if (tbl_bsize_q[mid_q] == '0) begin
            ack_q   <= NUM_REQ'(1) << gnt_q;
            err_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            rc_start_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          // The START cycle counts as the first waited cycle, so the
          // timeout ack lands exactly TIMEOUT cycles after rc_start.
          rc_start_q <= 1'b0;
          cnt_q      <= CNT_W'(1);
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rc_done) begin
            ack_q   <= NUM_REQ'(1) << gnt_q;
            err_q   <= 1'b0;
            state_q <= S_ACK;
          end else if (TIMEOUT != 0 && cnt_q >= TO_LAST) begin
            ack_q   <= NUM_REQ'(1) << gnt_q;
            err_q   <= 1'b1;
            fault_q <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q <= '0;
          err_q <= 1'b0;
          rr_q  <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
          if (fault_q) begin
            state_q <= S_FAULT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign rc_start = rc_start_q;
  assign rc_bop   = rc_bop_q;
  assign rc_baddr = rc_baddr_q;
  assign rc_bsize = rc_bsize_q;

endmodule

// File: tb/tb_rc_scheduler.sv
// Directed bench for rc_scheduler: one default-timeout instance for the main
// scenarios and one TIMEOUT=16 instance for the timeout/fault scenario.
module tb_rc_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_to;
  logic [3:0]  req_op;
  logic [15:0] req_mid;
  logic        tbl_we;
  logic [3:0]  tbl_waddr;
  logic [31:0] tbl_baddr;
  logic [31:0] tbl_bsize;
  logic        rc_done;
  logic        rc_done_to;

  logic [3:0]  ack,      ack_to;
  logic        err,      err_to;
  logic        busy,     busy_to;
  logic        fault,    fault_to;
  logic        rc_start, rc_start_to;
  logic        rc_bop,   rc_bop_to;
  logic [31:0] rc_baddr, rc_baddr_to;
  logic [31:0] rc_bsize, rc_bsize_to;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rc_scheduler #(.NUM_REQ(4), .MID_W(4), .TIMEOUT(65536)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_mid(req_mid),
    .ack(ack), .err(err), .busy(busy), .fault(fault),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_baddr(tbl_baddr), .tbl_bsize(tbl_bsize),
    .rc_start(rc_start), .rc_bop(rc_bop), .rc_baddr(rc_baddr), .rc_bsize(rc_bsize),
    .rc_done(rc_done)
  );

  rc_scheduler #(.NUM_REQ(4), .MID_W(4), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .req(req_to), .req_op(req_op), .req_mid(req_mid),
    .ack(ack_to), .err(err_to), .busy(busy_to), .fault(fault_to),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_baddr(tbl_baddr), .tbl_bsize(tbl_bsize),
    .rc_start(rc_start_to), .rc_bop(rc_bop_to), .rc_baddr(rc_baddr_to), .rc_bsize(rc_bsize_to),
    .rc_done(rc_done_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input logic [3:0] idx, input logic [31:0] ba, input logic [31:0] bs);
    tbl_we = 1'b1; tbl_waddr = idx; tbl_baddr = ba; tbl_bsize = bs;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for rc_start, answers with rc_done, checks the ack vector.
  task automatic serve(input logic [3:0] exp_ack, input string tag);
    int w = 0;
    while (rc_start !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_start"}, {31'd0, rc_start}, 32'd1);
    repeat (2) tick();
    rc_done = 1'b1;
    tick();
    rc_done = 1'b0;
    chk({tag, "_ack"}, {28'd0, ack}, {28'd0, exp_ack});
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    req = req & ~ack;
  endtask

  task automatic chk_all_zero(input string tag, input logic [3:0] a, input logic e, input logic b,
                              input logic f, input logic s, input logic o,
                              input logic [31:0] ba, input logic [31:0] bs);
    chk({tag, "_ack"},   {28'd0, a}, 32'd0);
    chk({tag, "_err"},   {31'd0, e}, 32'd0);
    chk({tag, "_busy"},  {31'd0, b}, 32'd0);
    chk({tag, "_fault"}, {31'd0, f}, 32'd0);
    chk({tag, "_start"}, {31'd0, s}, 32'd0);
    chk({tag, "_bop"},   {31'd0, o}, 32'd0);
    chk({tag, "_baddr"}, ba, 32'd0);
    chk({tag, "_bsize"}, bs, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_to = '0; req_op = '0; req_mid = '0;
    tbl_we = 1'b0; tbl_waddr = '0; tbl_baddr = '0; tbl_bsize = '0;
    rc_done = 1'b0; rc_done_to = 1'b0;
    repeat (2) tick();
    chk_all_zero("rst", ack, err, busy, fault, rc_start, rc_bop, rc_baddr, rc_bsize);
    rst = 1'b0;

    // Write config through requester 1
    tbl_write(4'd3, 32'h1000, 32'd8);
    req_op = 4'b0010; req_mid = 16'h0030; req = 4'b0010;
    tick();
    chk("wr_lookup_busy", {31'd0, busy}, 32'd1);
    chk("wr_lookup_start", {31'd0, rc_start}, 32'd0);
    tick();
    chk("wr_start", {31'd0, rc_start}, 32'd1);
    chk("wr_bop", {31'd0, rc_bop}, 32'd1);
    chk("wr_baddr", rc_baddr, 32'h1000);
    chk("wr_bsize", rc_bsize, 32'd8);
    tick();
    chk("wr_start_pulse", {31'd0, rc_start}, 32'd0);
    repeat (19) tick();
    chk("wr_no_early_ack", {28'd0, ack}, 32'd0);
    rc_done = 1'b1;
    tick();
    rc_done = 1'b0; req = '0;
    chk("wr_ack", {28'd0, ack}, 32'b0010);
    chk("wr_err", {31'd0, err}, 32'd0);
    tick();
    chk("wr_ack_pulse", {28'd0, ack}, 32'd0);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr_hold_baddr", rc_baddr, 32'h1000);

    // Round-robin from a fresh pointer
    do_reset();
    tbl_write(4'd3, 32'h1000, 32'd8);
    req_op = 4'b0000; req_mid = 16'h3333; req = 4'b1111;
    serve(4'b0001, "rr0");
    serve(4'b0010, "rr1");
    serve(4'b0100, "rr2");
    serve(4'b1000, "rr3");
    tick();
    req = 4'b0101;
    serve(4'b0001, "rr4");
    serve(4'b0100, "rr5");
    tick();

    // Invalid descriptor: mid 5 never written
    req_mid = 16'h0500; req_op = 4'b0100; req = 4'b0100;
    tick();
    chk("inv_lookup_ack", {28'd0, ack}, 32'd0);
    tick();
    chk("inv_ack", {28'd0, ack}, 32'b0100);
    chk("inv_err", {31'd0, err}, 32'd1);
    chk("inv_no_start", {31'd0, rc_start}, 32'd0);
    chk("inv_bsize", rc_bsize, 32'd0);
    req = '0;
    tick();
    chk("inv_idle", {31'd0, busy}, 32'd0);

    // Concurrent table write during WAIT
    req_mid = 16'h0030; req_op = 4'b0010; req = 4'b0010;
    repeat (3) tick();
    tbl_write(4'd3, 32'h2000, 32'd4);
    repeat (3) tick();
    chk("cw_wait_baddr", rc_baddr, 32'h1000);
    rc_done = 1'b1;
    tick();
    rc_done = 1'b0; req = '0;
    chk("cw_ack", {28'd0, ack}, 32'b0010);
    chk("cw_ack_baddr", rc_baddr, 32'h1000);
    chk("cw_ack_bsize", rc_bsize, 32'd8);
    tick();
    req = 4'b0010;
    tick();
    // Write in the LOOKUP cycle is not seen by this lookup
    tbl_write(4'd3, 32'h3000, 32'd2);
    chk("cw_new_start", {31'd0, rc_start}, 32'd1);
    chk("cw_new_baddr", rc_baddr, 32'h2000);
    chk("cw_new_bsize", rc_bsize, 32'd4);

    // Reset mid-operation (now in WAIT)
    tick();
    chk("rm_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk_all_zero("rm", ack, err, busy, fault, rc_start, rc_bop, rc_baddr, rc_bsize);
    req = 4'b0010;
    repeat (2) tick();
    chk("rm_cleared_ack", {28'd0, ack}, 32'b0010);
    chk("rm_cleared_err", {31'd0, err}, 32'd1);
    req = '0;
    tick();

    // Timeout on the TIMEOUT=16 instance
    tbl_write(4'd3, 32'h1000, 32'd8);
    req_mid = 16'h0003; req_op = 4'b0001; req_to = 4'b0001;
    repeat (2) tick();
    chk("to_start", {31'd0, rc_start_to}, 32'd1);
    repeat (15) tick();
    chk("to_no_early_ack", {28'd0, ack_to}, 32'd0);
    chk("to_no_early_fault", {31'd0, fault_to}, 32'd0);
    tick();
    chk("to_ack", {28'd0, ack_to}, 32'b0001);
    chk("to_err", {31'd0, err_to}, 32'd1);
    chk("to_fault", {31'd0, fault_to}, 32'd1);
    req_to = 4'b0010; req_mid = 16'h0030;
    rc_done_to = 1'b1;
    tick();
    rc_done_to = 1'b0;
    repeat (5) tick();
    chk("to_fault_hold", {31'd0, fault_to}, 32'd1);
    chk("to_busy_hold", {31'd0, busy_to}, 32'd1);
    chk("to_no_grant_ack", {28'd0, ack_to}, 32'd0);
    chk("to_no_grant_start", {31'd0, rc_start_to}, 32'd0);
    req_to = '0;
    do_reset();
    chk_all_zero("to_rst", ack_to, err_to, busy_to, fault_to, rc_start_to, rc_bop_to,
                 rc_baddr_to, rc_bsize_to);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
